// File: rtl/prog_feeder.sv
// prog_feeder: program memory sequencer feeding a two-step processor's din/run.
// Define FEEDER_DONE_CHECK_EN to cross-check the processor's done strobe each cycle.
module prog_feeder #(
  parameter int REG_WIDTH         = 16,
  parameter int INSTRUCTION_WIDTH = 9,
  parameter int ADDR_WIDTH        = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_en_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [REG_WIDTH-1:0]  load_data_i,
  input  logic [ADDR_WIDTH:0]   prog_len_i,
  input  logic                  start_i,
  input  logic                  done_i,
  output logic                  run_o,
  output logic [REG_WIDTH-1:0]  din_out_o,
  output logic [ADDR_WIDTH:0]   pc_o,
  output logic                  busy_o,
  output logic                  finished_o,
  output logic                  error_o
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, STOP} state_t;
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  state_t state_q, state_d;
  logic [ADDR_WIDTH:0] pc_q, pc_d, len_q, len_d, pc_inc, pc_nx;
  logic mvi_q, mvi_d, fin_q, fin_d, err_q, err_d, done_bad;
  logic [REG_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [REG_WIDTH-1:0] word;
  logic [2:0] op;
  assign word   = mem[pc_q[ADDR_WIDTH-1:0]];
  assign op     = word[INSTRUCTION_WIDTH-1 -: 3];
  assign pc_inc = pc_q + ONE;
`ifdef FEEDER_DONE_CHECK_EN
  // done must be low at t0 and high at t1
  assign done_bad = (state_q == FETCH && done_i) || (state_q == EXEC && !done_i);
`else
  logic unused_done;
  assign unused_done = done_i;
  assign done_bad    = 1'b0;
`endif
  always_ff @(posedge clk_i)
    if (load_en_i && state_q == IDLE) mem[load_addr_i] <= load_data_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      mvi_q   <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      mvi_q   <= mvi_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
    end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    mvi_d   = mvi_q;
    fin_d   = fin_q;
    err_d   = err_q;
    pc_nx   = mvi_q ? pc_inc : pc_q;
    case (state_q)
      IDLE: if (start_i) begin
        len_d   = prog_len_i;
        pc_d    = '0;
        err_d   = 1'b0;
        fin_d   = prog_len_i == '0;
        state_d = prog_len_i == '0 ? STOP : FETCH;
      end
      FETCH: if (!done_bad && (op == 3'd0 || (op == 3'd1 && pc_inc < len_q))) begin
        mvi_d   = op == 3'd1;
        pc_d    = pc_inc;
        state_d = EXEC;
      end else begin
        err_d   = 1'b1;
        state_d = STOP;
      end
      EXEC: if (done_bad) begin
        err_d   = 1'b1;
        state_d = STOP;
      end else begin
        pc_d    = pc_nx;
        fin_d   = pc_nx >= len_q;
        state_d = pc_nx < len_q ? FETCH : STOP;
      end
      default: state_d = IDLE;
    endcase
  end
  assign run_o      = state_q == FETCH || state_q == EXEC;
  assign din_out_o  = (state_q == FETCH || (state_q == EXEC && mvi_q)) ? word : '0;
  assign pc_o       = pc_q;
  assign busy_o     = state_q != IDLE;
  assign finished_o = fin_q;
  assign error_o    = err_q;
endmodule

// File: tb/tb_prog_feeder.sv
// tb_prog_feeder: randomized and directed checks of prog_feeder against an instruction-level model.
module tb_prog_feeder;
  localparam int RW = 16, AW = 4, D = 16;
  logic clk = 1'b0, rst_n, load_en, start, done, run, busy, finished, error;
  logic [AW-1:0] load_addr;
  logic [RW-1:0] load_data, din_out;
  logic [AW:0] prog_len, pc;
  logic [RW-1:0] m [D];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  prog_feeder dut (
    .clk_i(clk), .rst_ni(rst_n), .load_en_i(load_en), .load_addr_i(load_addr),
    .load_data_i(load_data), .prog_len_i(prog_len), .start_i(start), .done_i(done),
    .run_o(run), .din_out_o(din_out), .pc_o(pc), .busy_o(busy),
    .finished_o(finished), .error_o(error)
  );

  task automatic load(input int a, input logic [RW-1:0] v);
    load_en = 1'b1; load_addr = a[AW-1:0]; load_data = v;
    @(negedge clk);
    load_en = 1'b0;
    m[a] = v;
  endtask

  task automatic load_directed();
    logic [RW-1:0] p [6] = '{16'h0040, 16'h0005, 16'h0008, 16'h0050, 16'h00A5, 16'h001A};
    for (int i = 0; i < 6; i++) load(i, p[i]);
  endtask

  // Model: walk the program one instruction at a time, listing what each cycle shows.
  task automatic run_prog(input int len, input int fault, input bit disturb,
                          input bit ld_start, input logic [RW-1:0] ld_val, input string name);
    logic [RW-1:0] ed[$];
    int ep[$];
    logic [RW-1:0] w;
    bit err = 0, fin = 0;
    int p = 0;
    if (ld_start) m[0] = ld_val;
    if (len == 0) fin = 1;
    while (len > 0) begin
      w = m[p];
      ed.push_back(w); ep.push_back(p);
      if (w[8:6] == 3'd0) begin
        p++; ed.push_back('0); ep.push_back(p);
      end else if (w[8:6] == 3'd1 && p + 1 < len) begin
        p++; ed.push_back(m[p]); ep.push_back(p); p++;
      end else begin
        err = 1; break;
      end
`ifdef FEEDER_DONE_CHECK_EN
      if (fault == ed.size() - 1) begin err = 1; break; end
`endif
      if (p >= len) begin fin = 1; break; end
    end
    prog_len = len[AW:0]; start = 1'b1;
    if (ld_start) begin load_en = 1'b1; load_addr = '0; load_data = ld_val; end
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    foreach (ed[i]) begin
      checks++;
      if (run !== 1'b1 || din_out !== ed[i] || pc !== ep[i][AW:0] || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s cycle %0d: got run=%b din=%h pc=%0d busy=%b, want run=1 din=%h pc=%0d busy=1",
                 name, i, run, din_out, pc, busy, ed[i], ep[i]);
      end
      done = (i % 2 == 1) && (i != fault);
      if (disturb && i == 1) begin
        start = 1'b1; prog_len = '0; load_en = 1'b1; load_addr = '0; load_data = ~m[0];
      end
      @(negedge clk);
      start = 1'b0; load_en = 1'b0; done = 1'b0;
    end
    checks++;
    if (run !== 1'b0 || din_out !== '0 || busy !== 1'b1 || finished !== fin || error !== err) begin
      failures++;
      $display("FAIL %s stop: got run=%b din=%h busy=%b fin=%b err=%b, want run=0 din=0000 busy=1 fin=%b err=%b",
               name, run, din_out, busy, finished, error, fin, err);
    end
    @(negedge clk);
    checks++;
    if (run !== 1'b0 || busy !== 1'b0 || finished !== fin || error !== err) begin
      failures++;
      $display("FAIL %s idle: got run=%b busy=%b fin=%b err=%b, want run=0 busy=0 fin=%b err=%b",
               name, run, busy, finished, error, fin, err);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (run !== 1'b0 || din_out !== '0 || pc !== '0 || busy !== 1'b0 || finished !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL reset: got run=%b din=%h pc=%0d busy=%b fin=%b err=%b, want all zero",
               run, din_out, pc, busy, finished, error);
    end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
  endtask

  task automatic test_directed();
    load_directed();
    run_prog(6, -1, 0, 0, '0, "directed");
  endtask

  task automatic test_mvi_trunc();
    load(0, 16'h0040);
    run_prog(1, -1, 0, 0, '0, "mvi_trunc");
  endtask

  task automatic test_illegal();
    load(0, 16'h0100);
    run_prog(3, -1, 0, 0, '0, "illegal_op");
  endtask

  task automatic test_done_check();
    load_directed();
    run_prog(6, 1, 0, 0, '0, "done_check");
  endtask

  task automatic test_busy_ignore();
    load_directed();
    run_prog(6, -1, 1, 0, '0, "busy_ignore");
    run_prog(6, -1, 0, 0, '0, "after_ignore");
    run_prog(0, -1, 0, 0, '0, "len0");
  endtask

  task automatic test_load_with_start();
    run_prog(6, -1, 0, 1, 16'h0038, "load_start");
  endtask

  task automatic test_boundary();
    for (int i = 0; i < D; i++) load(i, RW'(i % 64));
    run_prog(16, -1, 0, 0, '0, "len16_mv");
    load(15, 16'h0078);
    run_prog(16, -1, 0, 0, '0, "len16_trunc");
  endtask

  task automatic test_async_reset();
    load_directed();
    prog_len = 5'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      done = i % 2 == 1;
      @(negedge clk);
      done = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (run !== 1'b0 || din_out !== '0 || pc !== '0 || busy !== 1'b0 || finished !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got run=%b din=%h pc=%0d busy=%b fin=%b err=%b, want all zero",
               run, din_out, pc, busy, finished, error);
    end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    run_prog(6, -1, 0, 0, '0, "restart");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      int len, fault;
      for (int i = 0; i < D; i++) begin
        int r;
        logic [2:0] op;
        logic [5:0] rr;
        r = $urandom_range(0, 15);
        rr = 6'($urandom);
        op = r < 7 ? 3'd0 : r < 14 ? 3'd1 : 3'($urandom_range(2, 7));
        load(i, r == 15 ? RW'($urandom) : {7'd0, op, rr});
      end
      len = $urandom_range(1, 16);
      fault = $urandom_range(0, 3) == 0 ? 2 * $urandom_range(0, 7) + 1 : -1;
      run_prog(len, fault, 0, 0, '0, "random");
    end
  endtask

  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0; done = 1'b0;
    test_reset();
    test_directed();
    test_mvi_trunc();
    test_illegal();
    test_done_check();
    test_busy_ignore();
    test_load_with_start();
    test_boundary();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
